// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register file and its scoreboard.
package rv_pkg;
    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-writeback flags: issue sets, writeback clears, a same-edge set wins.
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic             bset,
    input  logic [AW-1:0]    bset_addr,
    output logic [NREGS-1:0] busy_vec
);

    logic [NREGS-1:1] r_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bset && (bset_addr == AW'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (we && (wa == AW'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // x0 never has a pending producer.
    assign busy_vec = {r_busy, 1'b0};

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with busy scoreboard.
// Define RF_WR_BYPASS_EN to forward same-cycle write data to matching read lanes.
module regfile_mp
    import rv_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [XLEN-1:0]   wd,
    input  logic              bset,
    input  logic [AW-1:0]     bset_addr,
    output logic [NREGS-1:0]  busy_vec
);

    // Flops rather than block RAM: the whole file must clear asynchronously.
    logic [XLEN-1:0] r_regs [1:NREGS-1];
    logic [XLEN-1:0] w_rf   [0:NREGS-1];
    logic [AW-1:0]   w_rd_addr [NRD];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (we && (wa == AW'(i))) begin
                    r_regs[i] <= wd;
                end
            end
        end
    end

    assign w_rf[0] = '0;
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
            assign w_rf[gi] = r_regs[gi];
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wa        (wa),
        .bset      (bset),
        .bset_addr (bset_addr),
        .busy_vec  (busy_vec)
    );

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_lane
            assign w_rd_addr[gi] = rd_addr[gi*AW +: AW];
`ifdef RF_WR_BYPASS_EN
            logic w_hit;
            // Gated by rst so nothing leaks through while the file is held in reset.
            assign w_hit = rst && we && (wa != AW'(REG_ZERO)) && (wa == w_rd_addr[gi]);
            assign rd_data[gi*XLEN +: XLEN] = w_hit ? wd : w_rf[w_rd_addr[gi]];
            assign rd_busy[gi] = w_hit ? (bset && (bset_addr == wa)) : busy_vec[w_rd_addr[gi]];
`else
            assign rd_data[gi*XLEN +: XLEN] = w_rf[w_rd_addr[gi]];
            assign rd_busy[gi] = busy_vec[w_rd_addr[gi]];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp with a queue-based scoreboard.
module tb_regfile_mp;
    import rv_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                we = 1'b0;
    logic [AW-1:0]       wa = '0;
    logic [XLEN-1:0]     wd = '0;
    logic                bset = 1'b0;
    logic [AW-1:0]       bset_addr = '0;
    logic [NREGS-1:0]    busy_vec;

    int checks = 0;
    int errors = 0;

    // Reference: architectural register values and pending flags.
    logic [XLEN-1:0] m_reg  [NREGS];
    logic            m_busy [NREGS];

    logic [NRD*XLEN-1:0] q_data [$];
    logic [NRD-1:0]      q_busy [$];
    logic [NREGS-1:0]    q_vec  [$];
    string               q_name [$];

    always #5 clk = ~clk;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .bset      (bset),
        .bset_addr (bset_addr),
        .busy_vec  (busy_vec)
    );

    task automatic model_clear();
        for (int r = 0; r < NREGS; r++) begin
            m_reg[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic push_expect(input string name);
        logic [NRD*XLEN-1:0] ed;
        logic [NRD-1:0]      eb;
        logic [NREGS-1:0]    ev;
        logic [AW-1:0]       a;
        logic                byp;
        for (int r = 0; r < NREGS; r++) ev[r] = rst ? m_busy[r] : 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a   = rd_addr[i*AW +: AW];
            byp = 1'b0;
`ifdef RF_WR_BYPASS_EN
            byp = rst && we && (wa != 0) && (wa == a);
`endif
            if (!rst)              ed[i*XLEN +: XLEN] = '0;
            else if (byp)          ed[i*XLEN +: XLEN] = wd;
            else if (a == 0)       ed[i*XLEN +: XLEN] = '0;
            else                   ed[i*XLEN +: XLEN] = m_reg[a];
            if (!rst)              eb[i] = 1'b0;
            else if (byp)          eb[i] = bset && (bset_addr == a);
            else                   eb[i] = m_busy[a];
        end
        q_data.push_back(ed);
        q_busy.push_back(eb);
        q_vec.push_back(ev);
        q_name.push_back(name);
    endtask

    // Caller sets inputs at a falling edge; expectation is queued, then the
    // reference applies the architectural update at the rising edge.
    task automatic cycle(input string name);
        push_expect(name);
        @(posedge clk);
        if (rst) begin
            if (we && wa != 0) begin
                m_reg[wa]  = wd;
                m_busy[wa] = 1'b0;
            end
            if (bset && bset_addr != 0) m_busy[bset_addr] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic set_rd_all(input logic [AW-1:0] a);
        for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = a;
    endtask

    task automatic idle();
        we   = 1'b0;
        bset = 1'b0;
    endtask

    // Monitor: samples the DUT one time unit after each expectation is queued.
    initial begin
        logic [NRD*XLEN-1:0] ed;
        logic [NRD-1:0]      eb;
        logic [NREGS-1:0]    ev;
        string               nm;
        forever begin
            wait (q_data.size() > 0);
            #1;
            ed = q_data.pop_front();
            eb = q_busy.pop_front();
            ev = q_vec.pop_front();
            nm = q_name.pop_front();
            checks++;
            if (rd_data !== ed) begin
                errors++;
                $display("FAIL %s rd_data got=%h exp=%h", nm, rd_data, ed);
            end
            checks++;
            if (rd_busy !== eb) begin
                errors++;
                $display("FAIL %s rd_busy got=%b exp=%b", nm, rd_busy, eb);
            end
            checks++;
            if (busy_vec !== ev) begin
                errors++;
                $display("FAIL %s busy_vec got=%h exp=%h", nm, busy_vec, ev);
            end
            $display("check %s rd_addr=%h rd_data=%h rd_busy=%b busy_vec=%h", nm, rd_addr, rd_data, rd_busy, busy_vec);
        end
    end

    initial begin
        model_clear();
        @(negedge clk);

        // Held in reset: writes and bset must be ignored.
        we = 1'b1; wa = 5; wd = 32'hDEADBEEF; bset = 1'b1; bset_addr = 5;
        set_rd_all(5);
        cycle("rst_hold");
        rst = 1'b1;
        idle();
        cycle("rst_release");
        cycle("rst_post");

        // Write latency.
        we = 1'b1; wa = 3; wd = 32'h12345678;
        set_rd_all(3);
        cycle("wr_same");
        idle();
        cycle("wr_after");

        // x0 hardwired.
        we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; bset = 1'b1; bset_addr = 0;
        set_rd_all(0);
        cycle("x0_write");
        idle();
        cycle("x0_after");

        // Scoreboard set / hold / clear.
        bset = 1'b1; bset_addr = 7;
        set_rd_all(7);
        cycle("sb_set");
        idle();
        cycle("sb_idle1");
        cycle("sb_idle2");
        we = 1'b1; wa = 7; wd = 32'd77;
        cycle("sb_clr_edge");
        idle();
        cycle("sb_clr_after");
        bset = 1'b1; bset_addr = 7;
        cycle("sb_reset7");
        we = 1'b1; wa = 7; wd = 32'd78;
        cycle("sb_same_edge");
        idle();
        cycle("sb_set_wins");

        // Multi-port reads.
        for (int k = 1; k <= 4; k++) begin
            we = 1'b1; wa = AW'(k); wd = XLEN'(10 + k);
            cycle($sformatf("mp_wr%0d", k));
        end
        idle();
        rd_addr = {AW'(4), AW'(3), AW'(2), AW'(1)};
        cycle("mp_read");
        set_rd_all(2);
        cycle("mp_same");

        // Asynchronous reset between edges.
        for (int k = 1; k <= 4; k++) begin
            bset = 1'b1; bset_addr = AW'(k);
            cycle($sformatf("ar_bset%0d", k));
        end
        idle();
        rd_addr = {AW'(4), AW'(3), AW'(2), AW'(1)};
        cycle("ar_before");
        #2;
        rst = 1'b0;
        model_clear();
        push_expect("ar_async");
        #2;
        rst = 1'b1;
        @(negedge clk);
        cycle("ar_after");

        // Random traffic, addresses biased low to force collisions.
        for (int n = 0; n < 400; n++) begin
            we        = ($urandom_range(0, 1) == 1);
            wa        = AW'($urandom_range(0, 7));
            wd        = $urandom;
            bset      = ($urandom_range(0, 2) == 0);
            bset_addr = AW'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) begin
                rd_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? wa
                                      : AW'($urandom_range(0, NREGS - 1));
            end
            cycle($sformatf("rnd%0d", n));
        end

        idle();
        #3;
        checks++;
        if (q_data.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", q_data.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file for the RISC-V core: the next generation of the single-cycle 2R/1W register file.
- Generalised in data width, register count and number of read ports.
- Adds a per-register busy scoreboard so a later pipelined datapath can detect pending writebacks.
- Adds optional write-to-read bypass.
- Sits between decode (read addresses, busy set) and writeback (write port).

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of two, >=2).
- NRD, 2, number of independent read ports (1..4).
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data, combinational.
- rd_busy  out  NRD  busy flag of each addressed register, combinational.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- bset  in  1  mark register bset_addr as pending (instruction issued).
- bset_addr  in  AW  register to mark busy.
- busy_vec  out  NREGS  full scoreboard, registered.

Behaviour:
- Reset: asserting rst low immediately clears all NREGS registers to 0 and all busy bits to 0, regardless of clk.
  - While rst is low, every rd_data lane reads 0, every rd_busy reads 0, and busy_vec is 0.
  - Writes and bset are ignored while rst is low.
  - Deasserting rst mid-cycle takes effect on the next rising edge; there are no partial writes.
- Register 0 is hardwired to zero:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0.
  - Busy bit 0 is never set; bset to address 0 is ignored.
- Write: on a rising edge with rst=1, we=1 and wa!=0, Registers[wa] <= wd. Data is visible to reads after that edge (1-cycle latency) unless the bypass is enabled.
- Read: fully combinational from rd_addr. Read ports are independent; any number of ports may address the same register.
- Scoreboard, per register r != 0, on each rising edge with rst=1:
  - Set: bset=1 and bset_addr==r sets busy[r].
  - Clear: we=1 and wa==r clears busy[r].
  - Simultaneous set and clear of the same r: set wins, so busy stays 1 (a new producer replaces the old one).
  - Set or clear of different registers in the same cycle: both apply.
  - Setting an already-busy register keeps it at 1; clearing an idle one keeps it at 0. No error is flagged.
- rd_busy[i] = busy_vec[rd_addr lane i], except as modified by the bypass below.
- Address width: addresses >= NREGS cannot occur because NREGS is a power of two.

Optional Feature:
- Macro: RF_WR_BYPASS_EN.
- Defined:
  - A read lane whose address equals wa while we=1 and wa!=0 returns wd in the same cycle (write-before-read).
  - That lane's rd_busy reads 0, unless bset targets the same register in that cycle.
- Undefined:
  - Same-cycle reads return the old register contents.
  - rd_busy reflects the registered busy_vec only.
- Write timing and scoreboard update are identical in both builds.

Decomposition:
- Shared package rv_pkg holds:
  - XLEN_DEFAULT=32, NREGS_DEFAULT=32.
  - The REG_ZERO address constant (0).
  - A typedef for the register-address type.
- One natural sub-module: regfile_scoreboard (busy_vec storage, set/clear priority, reset), instantiated once.
- The storage array and read muxes stay in regfile_mp.

Test Plan:
- Reset: hold rst=0, drive we=1 wa=5 wd=32'hDEADBEEF and read addr 5 on all ports. Required: rd_data=0 and busy_vec=0; after rst=1 and one idle edge, reg 5 still reads 0.
- Write/read latency: write wa=3 wd=32'h12345678. Required: port0 at addr 3 reads 32'h12345678 the cycle after the edge. With RF_WR_BYPASS_EN it reads the value in the same cycle; without it, it reads 0 in the same cycle.
- x0: write wa=0 wd=32'hFFFFFFFF and bset_addr=0. Required: all ports at addr 0 read 0 and busy_vec[0]=0.
- Scoreboard: bset addr 7, then 2 idle cycles, then we wa=7. Required: busy_vec[7]=1 for cycles 1-3 and 0 after the write edge. Same-edge bset=7 with we wa=7 leaves busy_vec[7]=1.
- Multi-port: NRD=4, write regs 1..4 with values 11..14, read addr {4,3,2,1}. Required: rd_data lanes {14,13,12,11}. All lanes at addr 2 read 12 on all four.
- Async reset mid-operation: busy on regs 1..4, pulse rst low for a half clock between edges. Required: busy_vec=0 and reads=0 immediately, without waiting for a clk edge.
